// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch queue slot; the PC is implicit (out_pc plus slot position).
  typedef struct packed {
    logic [XLEN-1:0] instr;
  } ifu_entry_t;

  // Ceiling log2, used to size pointers and counters.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Prefetch queue: synchronous FIFO with flush. Flush wins over push/pop.
// Storage is not reset; only pointers and count are.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  ifu_entry_t       push_data_i,
  input  logic             pop_i,
  output ifu_entry_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = clog2(DEPTH);

  ifu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  // Empty queue presents zero so the head word is defined after reset.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full queue is legal only alongside a pop.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Next pointer and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch, prefetch queue,
// redirect flush with discard of stale responses.
// Optional build macro IFU_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins_out,
  output logic [XLEN-1:0] ins_addr
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] occupancy;
  logic [SUM_W-1:0] inflight;
  logic             credit_ok;
  logic             handshake;
  logic             rsp_drop;
  logic             q_push, q_pop, q_full, q_empty;
  ifu_entry_t       q_head, q_push_data;
  logic [XLEN-1:0]  redirect_pc;

  // Words already queued plus words still in flight must fit in the queue.
  assign inflight  = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign credit_ok = (inflight < SUM_W'(DEPTH));

  // Held in reset and during a redirect cycle so no handshake can occur there.
  assign mem_req_valid = rst_n && credit_ok && !redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign handshake     = mem_req_valid && mem_req_ready;

  assign rsp_drop          = mem_rsp_valid && (discard_q != '0);
  assign q_push            = mem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign q_pop             = ins_valid && ins_ready && !redirect_valid;
  assign q_push_data.instr = mem_rsp_data;
  assign redirect_pc       = {redirect_addr[XLEN-1:2], 2'b00};

  assign ins_valid = !q_empty;
  assign ins_out   = q_head.instr;
  assign ins_addr  = out_pc_q;

  ifu_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (occupancy)
  );

  // PC and credit bookkeeping; redirect overrides everything else.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    out_pc_d      = out_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(mem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      out_pc_d   = redirect_pc;
      // Everything still in flight is stale; a same-cycle response is dropped now.
      discard_d  = outstanding_q - CNT_W'(mem_rsp_valid);
    end else begin
      if (handshake) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_drop)  discard_d  = discard_q - CNT_W'(1);
      if (q_pop)     out_pc_d   = out_pc_q + PC_STEP;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      out_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      out_pc_q      <= out_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Decode-starved cycles (saturating) and redirect count (wrapping).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ins_ready && !ins_valid && !redirect_valid && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect_valid)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

  // A response with nothing in flight means the memory broke the protocol.
  a_no_outstanding_underflow : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rsp_valid |-> (outstanding_q != '0));

  // Credit guarantees the queue never receives a push it cannot hold.
  a_no_queue_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) q_push |-> (!q_full || q_pop));

  // In-flight count can never exceed the queue depth.
  a_outstanding_bound : assert property (
    @(posedge clk) disable iff (!rst_n) outstanding_q <= CNT_W'(DEPTH));

endmodule
